// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, flag bundle and widths.
// Imported by the interface, the compute core and the pipeline top.
package alu_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    EQ      = 4'd0,
    LT      = 4'd1,
    LTU     = 4'd2,
    GT      = 4'd3,
    GTU     = 4'd4,
    ADD     = 4'd5,
    ADDU    = 4'd6,
    SUB     = 4'd7,
    SLL     = 4'd8,
    SRL     = 4'd9,
    SRA     = 4'd10,
    OR      = 4'd11,
    XOR     = 4'd12,
    AND     = 4'd13,
    SATADD  = 4'd14,
    ILLEGAL = 4'd15
  } opcode_e;

  typedef struct packed {
    logic z;
    logic v;
    logic c;
    logic n;
  } flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle of alu_pipe; master drives operands,
// slave (the ALU) returns results.
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    A;
  logic [WIDTH-1:0]    B;
  logic [OPCODE_W-1:0] Alu_Cntrl;
  logic                Cin;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    OUT;
  logic                Zero;
  logic                oVerflow;
  logic                Carry;
  logic                Negative;
  logic                op_err;

  modport master (
    output in_valid, A, B, Alu_Cntrl, Cin, out_ready,
    input  in_ready, out_valid, OUT, Zero, oVerflow, Carry, Negative, op_err
  );

  modport slave (
    input  in_valid, A, B, Alu_Cntrl, Cin, out_ready,
    output in_ready, out_valid, OUT, Zero, oVerflow, Carry, Negative, op_err
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: compares, add/sub, shifts, logic ops and
// saturating add, producing the result, Z/V/C/N flags and an illegal-opcode flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OPCODE_W-1:0] op,
  input  logic                cin,
  output logic [WIDTH-1:0]    result,
  output flags_t              flags,
  output logic                op_err
);
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   ONE_W1  = {{WIDTH{1'b0}}, 1'b1};

  opcode_e          op_s;
  logic [SH_W-1:0]  shamt_s;
  logic [WIDTH:0]   cin_w1_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH:0]   sat_sum_s;

  assign op_s     = opcode_e'(op);
  assign shamt_s  = b[SH_W-1:0];
  assign cin_w1_s = {{WIDTH{1'b0}}, cin};
  assign add_s    = {1'b0, a} + {1'b0, b} + cin_w1_s;
  // Subtraction carry is "no borrow": ~B is zero-extended before the +1.
  assign sub_s    = {1'b0, a} + {1'b0, ~b} + ONE_W1 + cin_w1_s;
  // Sign-extended to WIDTH+1 so A+B+Cin can never wrap before clamping.
  assign sat_sum_s = {a[WIDTH-1], a} + {b[WIDTH-1], b} + cin_w1_s;

  // Opcode decode and result/flag selection.
  always_comb begin
    result  = '0;
    flags   = '0;
    op_err  = 1'b0;
    case (op_s)
      EQ:   flags.z = (a == b);
      LT:   flags.z = ($signed(a) < $signed(b));
      LTU:  flags.z = (a < b);
      GT:   flags.z = ($signed(a) > $signed(b));
      GTU:  flags.z = (a > b);
      ADD, ADDU: begin
        result  = add_s[WIDTH-1:0];
        flags.c = add_s[WIDTH];
        flags.v = (a[WIDTH-1] == b[WIDTH-1]) & (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        result  = sub_s[WIDTH-1:0];
        flags.c = sub_s[WIDTH];
        flags.v = (a[WIDTH-1] != b[WIDTH-1]) & (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      SLL:  result = a << shamt_s;
      SRL:  result = a >> shamt_s;
      SRA:  result = $unsigned($signed(a) >>> shamt_s);
      OR:   result = a | b;
      XOR:  result = a ^ b;
      AND:  result = a & b;
      SATADD: begin
        if (sat_sum_s[WIDTH] != sat_sum_s[WIDTH-1]) begin
          flags.v = 1'b1;
          result  = sat_sum_s[WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
          result  = sat_sum_s[WIDTH-1:0];
        end
      end
      ILLEGAL: op_err = 1'b1;
      default: op_err = 1'b1;
    endcase
    flags.n = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 captures operands, S2 holds the
// computed result; also keeps a sticky overflow flag and a saturating op counter.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_pipe_if.slave        bus,
  input  logic             clr_sticky,
  output logic             sticky_v,
  output logic [CNT_W-1:0] op_count
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                s1_valid_r;
  logic [WIDTH-1:0]    s1_a_r;
  logic [WIDTH-1:0]    s1_b_r;
  logic [OPCODE_W-1:0] s1_op_r;
  logic                s1_cin_r;

  logic                s2_valid_r;
  logic [WIDTH-1:0]    s2_result_r;
  flags_t              s2_flags_r;
  logic                s2_err_r;

  logic                sticky_r;
  logic [CNT_W-1:0]    count_r;

  logic [WIDTH-1:0]    core_result_s;
  flags_t              core_flags_s;
  logic                core_err_s;
  logic                s2_load_s;
  logic                in_ready_s;
  logic                accept_s;
  logic                consume_s;

  // S2 can take a new entry when it is empty or its result leaves this cycle;
  // reset level gates in_ready so nothing is accepted while held in reset.
  assign s2_load_s  = ~s2_valid_r | bus.out_ready;
  assign in_ready_s = reset & (~s1_valid_r | s2_load_s);
  assign accept_s   = bus.in_valid & in_ready_s;
  assign consume_s  = s2_valid_r & bus.out_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a_r),
    .b      (s1_b_r),
    .op     (s1_op_r),
    .cin    (s1_cin_r),
    .result (core_result_s),
    .flags  (core_flags_s),
    .op_err (core_err_s)
  );

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_op_r    <= '0;
      s1_cin_r   <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= bus.A;
      s1_b_r     <= bus.B;
      s1_op_r    <= bus.Alu_Cntrl;
      s1_cin_r   <= bus.Cin;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: result register, held while downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= '0;
      s2_flags_r  <= '0;
      s2_err_r    <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_result_r <= core_result_s;
        s2_flags_r  <= core_flags_s;
        s2_err_r    <= core_err_s;
      end
    end
  end

  // Sticky overflow: a consumed overflowing result beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_r <= 1'b0;
    end else if (consume_s && s2_flags_r.v) begin
      sticky_r <= 1'b1;
    end else if (clr_sticky) begin
      sticky_r <= 1'b0;
    end
  end

  // Accepted-operation counter, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (accept_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.OUT       = s2_result_r;
  assign bus.Zero      = s2_flags_r.z;
  assign bus.oVerflow  = s2_flags_r.v;
  assign bus.Carry     = s2_flags_r.c;
  assign bus.Negative  = s2_flags_r.n;
  assign bus.op_err    = s2_err_r;
  assign sticky_v      = sticky_r;
  assign op_count      = count_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: scoreboard model of results, handshake,
// sticky flag and counter, plus directed cases with hand-computed values.
`timescale 1ns/1ps
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr_sticky = 1'b0;
  logic        sticky_v;
  logic [15:0] op_count;
  logic        clr8 = 1'b0;
  logic        sticky8;
  logic [3:0]  count8;

  alu_pipe_if #(.WIDTH(32)) bus ();
  alu_pipe_if #(.WIDTH(8))  bus8 ();

  alu_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .clr_sticky(clr_sticky),
    .sticky_v(sticky_v), .op_count(op_count));

  alu_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8), .clr_sticky(clr8),
    .sticky_v(sticky8), .op_count(count8));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    bit z, v, c, n, err;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   consumed = 0;
  bit   sticky_m = 1'b0;
  int   cnt_m = 0;
  bit   exp_rdy, exp_vld;
  exp_t e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference behaviour straight from the opcode definitions, using wide signed math.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic cin);
    exp_t   r;
    longint sa, sbv, ua, ub, ci, s;
    logic [63:0] w;
    r = '{default: 0};
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ci = longint'({63'd0, cin});
    case (op)
      4'd0: r.z = (a == b);
      4'd1: r.z = (sa < sbv);
      4'd2: r.z = (ua < ub);
      4'd3: r.z = (sa > sbv);
      4'd4: r.z = (ua > ub);
      4'd5, 4'd6: begin
        w = 64'(ua + ub + ci);
        r.out = w[31:0];
        r.c = w[32];
        s = sa + sbv + ci;
        r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: begin
        w = 64'(ua + (longint'(~b) & 64'hFFFF_FFFF) + 64'sd1 + ci);
        r.out = w[31:0];
        r.c = w[32];
        r.v = (a[31] != b[31]) && (r.out[31] != a[31]);
      end
      4'd8: r.out = a << b[4:0];
      4'd9: r.out = a >> b[4:0];
      4'd10: begin
        w = 64'(sa >>> b[4:0]);
        r.out = w[31:0];
      end
      4'd11: r.out = a | b;
      4'd12: r.out = a ^ b;
      4'd13: r.out = a & b;
      4'd14: begin
        s = sa + sbv + ci;
        if (s > 64'sd2147483647) begin
          r.out = 32'h7FFF_FFFF;
          r.v = 1'b1;
        end else if (s < -64'sd2147483648) begin
          r.out = 32'h8000_0000;
          r.v = 1'b1;
        end else begin
          w = 64'(s);
          r.out = w[31:0];
        end
      end
      default: r.err = 1'b1;
    endcase
    r.n = r.out[31];
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom());
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: check DUT against the model on every cycle, then advance the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out", 64'(bus.OUT), 64'd0);
      check("rst_flags", 64'({bus.Zero, bus.oVerflow, bus.Carry, bus.Negative, bus.op_err}), 64'd0);
      check("rst_sticky", 64'(sticky_v), 64'd0);
      check("rst_count", 64'(op_count), 64'd0);
      exp_q.delete();
      acc_q.delete();
      sticky_m = 1'b0;
      cnt_m = 0;
    end else begin
      exp_rdy = (exp_q.size() < 2) || bus.out_ready;
      exp_vld = (exp_q.size() > 0) && (cyc >= acc_q[0] + 1);
      check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      check("out_valid", 64'(bus.out_valid), 64'(exp_vld));
      check("sticky_v", 64'(sticky_v), 64'(sticky_m));
      check("op_count", 64'(op_count), 64'(cnt_m));
      if (bus.out_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        check("result", 64'(bus.OUT), 64'(e.out));
        check("flags", 64'({bus.Zero, bus.oVerflow, bus.Carry, bus.Negative, bus.op_err}),
              64'({e.z, e.v, e.c, e.n, e.err}));
      end
      if (exp_vld && bus.out_ready) begin
        if (exp_q[0].v) sticky_m = 1'b1;
        else if (clr_sticky) sticky_m = 1'b0;
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        consumed++;
      end else if (clr_sticky) begin
        sticky_m = 1'b0;
      end
      if (bus.in_valid && exp_rdy) begin
        exp_q.push_back(model(bus.A, bus.B, bus.Alu_Cntrl, bus.Cin));
        acc_q.push_back(cyc + 1);
        if (cnt_m < 65535) cnt_m++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic cin);
    bit ok = 1'b0;
    bus.A = a; bus.B = b; bus.Alu_Cntrl = op; bus.Cin = cin; bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("send_accept", 64'(ok), 64'd1);
  endtask

  // One operation on an idle pipe with out_ready=1; literal result and flags {Z,V,C,N,err}.
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic cin,
                         input logic [31:0] want_out, input logic [4:0] want_fl);
    int n = 0;
    bus.out_ready = 1'b1;
    send(a, b, op, cin);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 10);
    check({name, "_latency"}, 64'(n), 64'd2);
    check({name, "_out"}, 64'(bus.OUT), 64'(want_out));
    check({name, "_flags"}, 64'({bus.Zero, bus.oVerflow, bus.Carry, bus.Negative, bus.op_err}),
          64'(want_fl));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int k, idx, c0, n8;
    bit fell, seen;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Alu_Cntrl = '0; bus.Cin = 1'b0;
    bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Alu_Cntrl = '0; bus8.Cin = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    run_one("add_wrap", 32'hFFFF_FFFF, 32'h1, 4'd5, 1'b0, 32'h0, 5'b00100);
    run_one("sub_neg",  32'h5, 32'h7, 4'd7, 1'b0, 32'hFFFF_FFFE, 5'b00010);
    run_one("lt_signed", 32'hFFFF_FFFF, 32'h1, 4'd1, 1'b0, 32'h0, 5'b10000);
    run_one("ltu",      32'hFFFF_FFFF, 32'h1, 4'd2, 1'b0, 32'h0, 5'b00000);
    run_one("illegal",  32'h1234_5678, 32'h9, 4'd15, 1'b1, 32'h0, 5'b00001);
    run_one("sra",      32'h8000_0000, 32'h4, 4'd10, 1'b0, 32'hF800_0000, 5'b00010);
    run_one("addc_ovf", 32'h7FFF_FFFF, 32'h0, 4'd6, 1'b1, 32'h8000_0000, 5'b01010);

    for (int i = 0; i < 600; i++) begin
      bus.A = pick();
      bus.B = pick();
      bus.Alu_Cntrl = 4'($urandom_range(0, 15));
      bus.Cin = 1'($urandom_range(0, 1));
      bus.in_valid = ($urandom_range(0, 4) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    clr_sticky = 1'b0;
    drain();

    // Ten back-to-back operations with a downstream stall on cycles 3-6.
    k = 0; idx = 0; fell = 1'b0; c0 = consumed;
    while (idx < 10 && k < 40) begin
      bus.out_ready = !(k >= 3 && k <= 6);
      bus.A = pick();
      bus.B = pick();
      bus.Alu_Cntrl = 4'($urandom_range(0, 14));
      bus.Cin = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) idx++;
      else fell = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    drain();
    check("stream_accepted", 64'(idx), 64'd10);
    check("stream_in_ready_fell", 64'(fell), 64'd1);
    check("stream_consumed", 64'(consumed - c0), 64'd10);

    clr_sticky = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    check("sticky_cleared", 64'(sticky_v), 64'd0);
    @(posedge clk); #1;
    run_one("satadd", 32'h7FFF_FFF0, 32'h20, 4'd14, 1'b0, 32'h7FFF_FFFF, 5'b01000);
    @(negedge clk);
    check("sticky_set", 64'(sticky_v), 64'd1);
    @(posedge clk); #1;

    // Reset with two operations in flight.
    bus.out_ready = 1'b0;
    send(32'h1, 32'h2, 4'd5, 1'b0);
    send(32'h3, 32'h4, 4'd12, 1'b0);
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_flight_no_valid", 64'(seen), 64'd0);
    check("rst_flight_count", 64'(op_count), 64'd0);
    check("rst_flight_sticky", 64'(sticky_v), 64'd0);
    @(posedge clk); #1;

    // Narrow instance: counter saturates at 4'hF after 20 acceptances.
    n8 = 0;
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 60 && n8 < 20; i++) begin
      bus8.A = 8'($urandom());
      bus8.B = 8'($urandom());
      bus8.Alu_Cntrl = 4'($urandom_range(0, 15));
      bus8.Cin = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus8.in_ready) n8++;
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("w8_accepts", 64'(n8), 64'd20);
    check("w8_count_sat", 64'(count8), 64'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter CNT_W, default 16, width of the accepted-operation counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 A, B  input  WIDTH each  operands.
REQ-008 Alu_Cntrl  input  4  opcode.
REQ-009 Cin  input  1  carry-in for opcodes 5, 6, 7 and 14.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 OUT  output  WIDTH  result.
REQ-013 Zero, oVerflow, Carry, Negative  output  1 each  flags Z, V, C, N.
REQ-014 op_err  output  1  the current result came from an illegal opcode.
REQ-015 sticky_v  output  1  oVerflow has been 1 on some result since the last clear.
REQ-016 clr_sticky  input  1  synchronous clear of sticky_v.
REQ-017 op_count  output  CNT_W  number of accepted operations.

Function
REQ-018 An operation is accepted on a cycle where in_valid and in_ready are both 1; a result is consumed on a cycle where out_valid and out_ready are both 1.
REQ-019 The pipeline has two register stages, S1 (operand capture) and S2 (compute and result register); without stalls, out_valid rises 2 cycles after acceptance.
REQ-020 in_ready = !S1.valid | !S2.valid | out_ready, so the block has no bubbles and sustains one operation per cycle.
REQ-021 While out_valid=1 and out_ready=0, OUT, the flags and op_err shall hold stable; no result is dropped or duplicated.
REQ-022 Opcodes 0-4 (EQ, LT signed, LTU, GT signed, GTU) shall produce Zero = comparison result, OUT = 0, C = 0, V = 0.
REQ-023 Opcodes 5 and 6 (ADD, ADDU) shall compute {C, OUT} = A + B + Cin over WIDTH+1 bits, with V = (A msb == B msb) & (OUT msb != A msb) and Z = 0.
REQ-024 Opcode 7 (SUB) shall compute {C, OUT} = A + (~B + 1) + Cin over WIDTH+1 bits, with V = (A msb != B msb) & (OUT msb != A msb) and Z = 0.
REQ-025 Opcodes 8, 9 and 10 (SLL, SRL, SRA) shall shift A by B[$clog2(WIDTH)-1:0], with Z = C = V = 0.
REQ-026 Opcodes 11, 12 and 13 (OR, XOR, AND) are bitwise operations, with Z = C = V = 0.
REQ-027 Opcode 14 (SATADD) is a signed A + B + Cin clamped to the range [-2^(WIDTH-1), 2^(WIDTH-1)-1]; V = 1 when the result is clamped, C = Z = 0.
REQ-028 Opcode 15 is illegal: OUT = 0, all flags 0, op_err = 1; it is still accepted and counted.
REQ-029 Negative = OUT msb for every opcode.
REQ-030 sticky_v is set on a consumed result whose V = 1 and cleared by clr_sticky; if both occur in the same cycle, the set wins.
REQ-031 op_count increments on each acceptance and saturates at all-ones, with no wrap-around.

Reset
REQ-032 While reset=0: S1.valid = S2.valid = 0, out_valid = 0, OUT = 0, all flags = 0, op_err = 0, sticky_v = 0, op_count = 0.
REQ-033 While reset=0, in_ready = 0.
REQ-034 Reset asserted mid-operation discards all in-flight operations, and no out_valid is produced for them.
REQ-035 The first acceptance shall occur no earlier than the first rising clk edge after reset deasserts.

Structure
REQ-036 A shared package alu_pkg shall hold the 4-bit opcode enum (16 values, names as listed above) and a flags struct {Z, V, C, N}.
REQ-037 Combinational compute shall reside in one sub-module, alu_core, parametrised by WIDTH; alu_pipe owns only the handshake, pipeline registers, sticky flag and counter.

Verification
REQ-038 WIDTH=32, ADD, A=FFFFFFFF, B=1, Cin=0, out_ready=1: 2 cycles later OUT=0, C=1, V=0, N=0.
REQ-039 SATADD, A=7FFFFFF0, B=20, Cin=0: OUT=7FFFFFFF, V=1, and sticky_v=1 the cycle after the result is consumed.
REQ-040 SUB, A=5, B=7, Cin=0: OUT=FFFFFFFE, N=1, C=0, V=0; LT, A=-1, B=1: Zero=1; LTU, A=FFFFFFFF, B=1: Zero=0.
REQ-041 Back-to-back stream of 10 operations with out_ready held 0 for cycles 3-6: results arrive in order, none lost, and in_ready falls once both stages are full.
REQ-042 Opcode 15 followed by SRA with A=80000000, B=4: op_err=1 then 0, and OUT=F8000000.
REQ-043 Reset pulsed low while 2 operations are in flight: no out_valid, op_count=0, sticky_v=0; with WIDTH=8 and CNT_W=4, 20 acceptances leave op_count=F.
